// File: rtl/regs_arbiter_pkg.sv
// regs_arbiter_pkg: shared widths, register count and requester encodings
// for the register-file arbiter.
package regs_arbiter_pkg;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int NREG = 16;
    typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_e;
    function automatic logic [NREG-1:0] onehot(input logic [AW-1:0] a);
        return NREG'(1) << a;
    endfunction
endpackage

// File: rtl/regs_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; the pointer names the requester that
// wins a tie and moves to the loser on every grant.
module rr_arb2
    import regs_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_elig,
    output logic [1:0] o_gnt
);
    req_e r_ptr;
    always_comb begin
        o_gnt[REQ_A] = i_elig[REQ_A] && (!i_elig[REQ_B] || r_ptr == REQ_A);
        o_gnt[REQ_B] = i_elig[REQ_B] && (!i_elig[REQ_A] || r_ptr == REQ_B);
    end
    always_ff @(posedge clk) begin
        if (rst)
            r_ptr <= REQ_A;
        else if (o_gnt[REQ_A])
            r_ptr <= REQ_B;
        else if (o_gnt[REQ_B])
            r_ptr <= REQ_A;
    end
endmodule

// File: rtl/regs_arbiter.sv
// regs_arbiter: arbitrates two requesters onto a shared register file's
// two read ports and one write port, stalling reads of reserved registers.
module regs_arbiter
    import regs_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_req_a,
    input  logic          rd_req_b,
    input  logic [AW-1:0] rd_ra0_a,
    input  logic [AW-1:0] rd_ra1_a,
    input  logic [AW-1:0] rd_ra0_b,
    input  logic [AW-1:0] rd_ra1_b,
    output logic          rd_gnt_a,
    output logic          rd_gnt_b,
    output logic          rd_vld_a,
    output logic          rd_vld_b,
    output logic [DW-1:0] rd_data0,
    output logic [DW-1:0] rd_data1,
    input  logic          wr_req_a,
    input  logic          wr_req_b,
    input  logic [AW-1:0] wr_addr_a,
    input  logic [AW-1:0] wr_addr_b,
    input  logic [DW-1:0] wr_data_a,
    input  logic [DW-1:0] wr_data_b,
    output logic          wr_gnt_a,
    output logic          wr_gnt_b,
    input  logic          rsv_a,
    input  logic          rsv_b,
    input  logic [AW-1:0] rsv_addr_a,
    input  logic [AW-1:0] rsv_addr_b,
    output logic [AW-1:0] rf_raddr0,
    output logic [AW-1:0] rf_raddr1,
    input  logic [DW-1:0] rf_rdata0,
    input  logic [DW-1:0] rf_rdata1,
    output logic          rf_wen,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata
);
    logic [NREG-1:0] r_rsv;
    logic [NREG-1:0] w_set;
    logic [NREG-1:0] w_clr;
    logic [1:0]      w_rd_elig;
    logic [1:0]      w_rd_gnt;
    logic [1:0]      w_wr_elig;
    logic [1:0]      w_wr_gnt;
    logic            r_vld_a;
    logic            r_vld_b;
    logic [AW-1:0]   r_raddr0;
    logic [AW-1:0]   r_raddr1;

    rr_arb2 u_rd_arb (.clk(clk), .rst(rst), .i_elig(w_rd_elig), .o_gnt(w_rd_gnt));
    rr_arb2 u_wr_arb (.clk(clk), .rst(rst), .i_elig(w_wr_elig), .o_gnt(w_wr_gnt));

    // Eligibility is gated by rst so every grant-derived output drops during reset.
    always_comb begin
        w_rd_elig[REQ_A] = !rst && rd_req_a && !r_rsv[rd_ra0_a] && !r_rsv[rd_ra1_a];
        w_rd_elig[REQ_B] = !rst && rd_req_b && !r_rsv[rd_ra0_b] && !r_rsv[rd_ra1_b];
        w_wr_elig[REQ_A] = !rst && wr_req_a;
        w_wr_elig[REQ_B] = !rst && wr_req_b;
        rd_gnt_a  = w_rd_gnt[REQ_A];
        rd_gnt_b  = w_rd_gnt[REQ_B];
        wr_gnt_a  = w_wr_gnt[REQ_A];
        wr_gnt_b  = w_wr_gnt[REQ_B];
        rf_raddr0 = rd_gnt_a ? rd_ra0_a : rd_gnt_b ? rd_ra0_b : r_raddr0;
        rf_raddr1 = rd_gnt_a ? rd_ra1_a : rd_gnt_b ? rd_ra1_b : r_raddr1;
        rf_wen    = wr_gnt_a || wr_gnt_b;
        rf_waddr  = wr_gnt_a ? wr_addr_a : wr_gnt_b ? wr_addr_b : '0;
        rf_wdata  = wr_gnt_a ? wr_data_a : wr_gnt_b ? wr_data_b : '0;
        rd_vld_a  = r_vld_a && !rst;
        rd_vld_b  = r_vld_b && !rst;
        rd_data0  = rf_rdata0;
        rd_data1  = rf_rdata1;
        w_clr     = rf_wen ? onehot(rf_waddr) : '0;
        w_set     = (rsv_a ? onehot(rsv_addr_a) : '0) | (rsv_b ? onehot(rsv_addr_b) : '0);
    end

    // A new reservation overrides a same-edge clear of the same register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsv    <= '0;
            r_vld_a  <= 1'b0;
            r_vld_b  <= 1'b0;
            r_raddr0 <= '0;
            r_raddr1 <= '0;
        end else begin
            r_rsv    <= (r_rsv & ~w_clr) | w_set;
            r_vld_a  <= rd_gnt_a;
            r_vld_b  <= rd_gnt_b;
            r_raddr0 <= rf_raddr0;
            r_raddr1 <= rf_raddr1;
        end
    end
endmodule

// File: tb/tb_regs_arbiter.sv
// tb_regs_arbiter: directed stimulus with a queue-based scoreboard; a negedge
// monitor checks grants every cycle, read data on rd_vld and writes on rf_wen.
module tb_regs_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        rd_req_a, rd_req_b;
    logic [3:0]  rd_ra0_a, rd_ra1_a, rd_ra0_b, rd_ra1_b;
    logic        rd_gnt_a, rd_gnt_b, rd_vld_a, rd_vld_b;
    logic [15:0] rd_data0, rd_data1;
    logic        wr_req_a, wr_req_b;
    logic [3:0]  wr_addr_a, wr_addr_b;
    logic [15:0] wr_data_a, wr_data_b;
    logic        wr_gnt_a, wr_gnt_b;
    logic        rsv_a, rsv_b;
    logic [3:0]  rsv_addr_a, rsv_addr_b;
    logic [3:0]  rf_raddr0, rf_raddr1, rf_waddr;
    logic [15:0] rf_rdata0, rf_rdata1, rf_wdata;
    logic        rf_wen;

    int n_cmp = 0;
    int n_err = 0;
    logic [3:0]  gq[$];
    logic [32:0] rdq[$];
    logic [19:0] wq[$];

    logic [15:0] mem [16];
    logic [3:0]  q0, q1;

    always #5 clk = ~clk;

    regs_arbiter dut (
        .clk(clk), .rst(rst),
        .rd_req_a(rd_req_a), .rd_req_b(rd_req_b),
        .rd_ra0_a(rd_ra0_a), .rd_ra1_a(rd_ra1_a), .rd_ra0_b(rd_ra0_b), .rd_ra1_b(rd_ra1_b),
        .rd_gnt_a(rd_gnt_a), .rd_gnt_b(rd_gnt_b), .rd_vld_a(rd_vld_a), .rd_vld_b(rd_vld_b),
        .rd_data0(rd_data0), .rd_data1(rd_data1),
        .wr_req_a(wr_req_a), .wr_req_b(wr_req_b), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
        .wr_data_a(wr_data_a), .wr_data_b(wr_data_b), .wr_gnt_a(wr_gnt_a), .wr_gnt_b(wr_gnt_b),
        .rsv_a(rsv_a), .rsv_b(rsv_b), .rsv_addr_a(rsv_addr_a), .rsv_addr_b(rsv_addr_b),
        .rf_raddr0(rf_raddr0), .rf_raddr1(rf_raddr1), .rf_rdata0(rf_rdata0), .rf_rdata1(rf_rdata1),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    // Register file: reset loads 0xA000+i, write lands at the edge, read address latched.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= 16'hA000 + 16'(i);
        end else if (rf_wen) begin
            mem[rf_waddr] <= rf_wdata;
        end
        q0 <= rf_raddr0;
        q1 <= rf_raddr1;
    end
    assign rf_rdata0 = mem[q0];
    assign rf_rdata1 = mem[q1];

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Inputs are already set; push this cycle's expected {rga,rgb,wga,wgb} and advance.
    task automatic step(input logic [3:0] g);
        gq.push_back(g);
        @(posedge clk);
        #1;
    endtask

    logic [3:0]  m_g;
    logic [32:0] m_r;
    logic [19:0] m_w;
    always @(negedge clk) begin
        if (gq.size() > 0) begin
            m_g = gq.pop_front();
            chk("grants", {44'b0, rd_gnt_a, rd_gnt_b, wr_gnt_a, wr_gnt_b}, {44'b0, m_g});
        end
        if (rd_vld_a || rd_vld_b) begin
            if (rdq.size() == 0) begin
                chk("unexpected_rd_vld", {46'b0, rd_vld_a, rd_vld_b}, 48'b0);
            end else begin
                m_r = rdq.pop_front();
                chk("rd_vld_who", {46'b0, rd_vld_a, rd_vld_b}, m_r[32] ? 48'b01 : 48'b10);
                chk("rd_data", {16'b0, rd_data0, rd_data1}, {16'b0, m_r[31:0]});
            end
        end
        if (rf_wen) begin
            if (wq.size() == 0) begin
                chk("unexpected_rf_wen", {47'b0, rf_wen}, 48'b0);
            end else begin
                m_w = wq.pop_front();
                chk("rf_write", {28'b0, rf_waddr, rf_wdata}, {28'b0, m_w});
            end
        end else begin
            chk("wr_idle_zero", {28'b0, rf_waddr, rf_wdata}, 48'b0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rd_req_a = 1'b1; rd_req_b = 1'b0; wr_req_a = 1'b1; wr_req_b = 1'b0;
        rd_ra0_a = 4'd0; rd_ra1_a = 4'd0; rd_ra0_b = 4'd0; rd_ra1_b = 4'd0;
        wr_addr_a = 4'd1; wr_addr_b = 4'd0; wr_data_a = 16'h5555; wr_data_b = 16'h0;
        rsv_a = 1'b0; rsv_b = 1'b0; rsv_addr_a = 4'd0; rsv_addr_b = 4'd0;
        @(posedge clk);
        #1;
        step(4'b0000);
        step(4'b0000);
        rst = 1'b0; rd_req_a = 1'b0; wr_req_a = 1'b0;
        chk("reset_rd_vld", {46'b0, rd_vld_a, rd_vld_b}, 48'b0);
        chk("reset_raddr", {40'b0, rf_raddr0, rf_raddr1}, 48'b0);

        // Both read at once: A first, then B; A's data arrives while B is granted.
        rd_req_a = 1'b1; rd_ra0_a = 4'd3; rd_ra1_a = 4'd4;
        rd_req_b = 1'b1; rd_ra0_b = 4'd6; rd_ra1_b = 4'd8;
        rdq.push_back({1'b0, 16'hA003, 16'hA004}); step(4'b1000);
        rd_req_a = 1'b0;
        rdq.push_back({1'b1, 16'hA006, 16'hA008}); step(4'b0100);
        rd_req_b = 1'b0;
        step(4'b0000);
        chk("raddr_hold", {40'b0, rf_raddr0, rf_raddr1}, {40'b0, 4'd6, 4'd8});

        // Continuous writes from both sides alternate.
        wr_req_a = 1'b1; wr_addr_a = 4'd9;  wr_data_a = 16'h1111;
        wr_req_b = 1'b1; wr_addr_b = 4'd10; wr_data_b = 16'h2222;
        for (int i = 0; i < 2; i++) begin
            wq.push_back({4'd9, 16'h1111});  step(4'b0010);
            wq.push_back({4'd10, 16'h2222}); step(4'b0001);
        end
        wr_req_a = 1'b0; wr_req_b = 1'b0;

        // Reserve r5; B's read of r5 stalls until the cycle after the write grant.
        rsv_a = 1'b1; rsv_addr_a = 4'd5; step(4'b0000);
        rsv_a = 1'b0;
        rd_req_b = 1'b1; rd_ra0_b = 4'd0; rd_ra1_b = 4'd5;
        step(4'b0000);
        step(4'b0000);
        wr_req_a = 1'b1; wr_addr_a = 4'd5; wr_data_a = 16'h1234;
        wq.push_back({4'd5, 16'h1234}); step(4'b0010);
        wr_req_a = 1'b0;
        rdq.push_back({1'b1, 16'hA000, 16'h1234}); step(4'b0100);
        rd_req_b = 1'b0;
        step(4'b0000);

        // Same-edge reserve and write of r7: reservation survives.
        rsv_b = 1'b1; rsv_addr_b = 4'd7;
        wr_req_b = 1'b1; wr_addr_b = 4'd7; wr_data_b = 16'h7777;
        wq.push_back({4'd7, 16'h7777}); step(4'b0001);
        rsv_b = 1'b0; wr_req_b = 1'b0;
        rd_req_a = 1'b1; rd_ra0_a = 4'd7; rd_ra1_a = 4'd7;
        step(4'b0000);
        step(4'b0000);
        wr_req_a = 1'b1; wr_addr_a = 4'd7; wr_data_a = 16'h7A7A;
        wq.push_back({4'd7, 16'h7A7A}); step(4'b0010);
        wr_req_a = 1'b0;
        rdq.push_back({1'b0, 16'h7A7A, 16'h7A7A}); step(4'b1000);
        rd_req_a = 1'b0;

        // Two reservations in one cycle, released one write at a time.
        rsv_a = 1'b1; rsv_addr_a = 4'd11; rsv_b = 1'b1; rsv_addr_b = 4'd12;
        step(4'b0000);
        rsv_a = 1'b0; rsv_b = 1'b0;
        rd_req_a = 1'b1; rd_ra0_a = 4'd11; rd_ra1_a = 4'd0;
        rd_req_b = 1'b1; rd_ra0_b = 4'd12; rd_ra1_b = 4'd12;
        step(4'b0000);
        wr_req_a = 1'b1; wr_addr_a = 4'd11; wr_data_a = 16'hB0B0;
        wr_req_b = 1'b1; wr_addr_b = 4'd12; wr_data_b = 16'hC0C0;
        wq.push_back({4'd12, 16'hC0C0}); step(4'b0001);
        wr_req_b = 1'b0;
        wq.push_back({4'd11, 16'hB0B0});
        rdq.push_back({1'b1, 16'hC0C0, 16'hC0C0}); step(4'b0110);
        rd_req_b = 1'b0; wr_req_a = 1'b0;
        rdq.push_back({1'b0, 16'hB0B0, 16'hA000}); step(4'b1000);
        rd_req_a = 1'b0;

        // Write and read of r2 granted together: read returns the new value.
        rd_req_a = 1'b1; rd_ra0_a = 4'd2; rd_ra1_a = 4'd1;
        wr_req_b = 1'b1; wr_addr_b = 4'd2; wr_data_b = 16'hBEEF;
        wq.push_back({4'd2, 16'hBEEF});
        rdq.push_back({1'b0, 16'hBEEF, 16'hA001}); step(4'b1001);
        rd_req_a = 1'b0; wr_req_b = 1'b0;
        step(4'b0000);

        // Back-to-back reads at full rate; pointer currently favours B.
        rd_req_a = 1'b1; rd_ra0_a = 4'd1;  rd_ra1_a = 4'd3;
        rd_req_b = 1'b1; rd_ra0_b = 4'd14; rd_ra1_b = 4'd15;
        for (int i = 0; i < 2; i++) begin
            rdq.push_back({1'b1, 16'hA00E, 16'hA00F}); step(4'b0100);
            rdq.push_back({1'b0, 16'hA001, 16'hA003}); step(4'b1000);
        end
        rd_req_a = 1'b0; rd_req_b = 1'b0;
        step(4'b0000);

        // Reset right after a read grant: no rd_vld, bitmap and pointers cleared.
        rsv_a = 1'b1; rsv_addr_a = 4'd6; step(4'b0000);
        rsv_a = 1'b0;
        rd_req_a = 1'b1; rd_ra0_a = 4'd4; rd_ra1_a = 4'd5;
        wr_req_a = 1'b1; wr_addr_a = 4'd13; wr_data_a = 16'hD00D;
        wq.push_back({4'd13, 16'hD00D}); step(4'b1010);
        rd_req_a = 1'b0; wr_req_a = 1'b0;
        rst = 1'b1; step(4'b0000);
        rst = 1'b0;
        chk("post_rst_rd_vld", {46'b0, rd_vld_a, rd_vld_b}, 48'b0);
        chk("post_rst_raddr", {40'b0, rf_raddr0, rf_raddr1}, 48'b0);
        rd_req_a = 1'b1; rd_ra0_a = 4'd6; rd_ra1_a = 4'd0;
        rd_req_b = 1'b1; rd_ra0_b = 4'd1; rd_ra1_b = 4'd1;
        wr_req_a = 1'b1; wr_addr_a = 4'd8; wr_data_a = 16'h8888;
        wr_req_b = 1'b1; wr_addr_b = 4'd9; wr_data_b = 16'h9999;
        wq.push_back({4'd8, 16'h8888});
        rdq.push_back({1'b0, 16'hA006, 16'hA000}); step(4'b1010);
        rd_req_a = 1'b0; wr_req_a = 1'b0;
        wq.push_back({4'd9, 16'h9999});
        rdq.push_back({1'b1, 16'hA001, 16'hA001}); step(4'b0101);
        rd_req_b = 1'b0; wr_req_b = 1'b0;
        step(4'b0000);
        step(4'b0000);
        @(negedge clk);
        #1;
        chk("gq_drained", 48'(gq.size()), 48'b0);
        chk("rdq_drained", 48'(rdq.size()), 48'b0);
        chk("wq_drained", 48'(wq.size()), 48'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
